sd_mount_ctrl: RTL

//  Parametrised N-slot SD routing and mount controller between hps_io (image mount events) and the core SPI master.
//  Per slot, routes SPI to a virtual sd_card instance or (slot 0 only) the physical SD pins.

---
 rtl/sd_mount_ctrl_pkg.sv | 22 ++
 rtl/sd_mount_ctrl_if.sv | 52 +++++
 rtl/sd_mount_ctrl_act_timer.sv | 38 +++
 rtl/sd_mount_ctrl.sv | 117 +++++++++++
 4 files changed

// File: rtl/sd_mount_ctrl_pkg.sv
// Shared types, constants and helpers for the SD mount/routing controller.
package sd_mount_pkg;

   // Upper bound on image slots / core chip-selects.
   localparam int MAX_IMG = 4;

   // Index of one slot; wide enough for every legal NUM_IMG.
   typedef logic [$clog2(MAX_IMG)-1:0] slot_idx_t;

   // Which kind of card the currently selected slot talks to.
   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,   // no slot selected, or a slot >0 with no virtual card
      SRC_VIRT = 2'd1,   // selected slot is routed to a virtual sd_card
      SRC_PHYS = 2'd2    // slot 0 routed to the physical SD pins
   } act_src_t;

   // Counter width able to hold the values 0..n inclusive.
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/sd_mount_ctrl_if.sv
// Bundle of the hps_io mount events, core SPI bus, virtual/physical card
// pins and status outputs of the SD mount controller.
interface sd_mount_ctrl_if #(
   parameter int NUM_IMG = 2
);
   // hps_io mount events
   logic [NUM_IMG-1:0] img_mounted;
   logic [NUM_IMG-1:0] img_present;
   // core SPI master
   logic [NUM_IMG-1:0] spi_ss_n;
   logic               spi_sck;
   logic               spi_mosi;
   logic               spi_miso;
   // virtual sd_card instances
   logic [NUM_IMG-1:0] vsd_ss_n;
   logic [NUM_IMG-1:0] vsd_miso;
   // physical SD pins
   logic               phys_ss_n;
   logic               phys_sck;
   logic               phys_mosi;
   logic               phys_miso;
   // status
   logic [NUM_IMG-1:0] vsd_sel;
   logic               reset_img;
   logic               act_virt;
   logic               act_phys;

   // Controller side.
   modport master (
      input  img_mounted, img_present,
      input  spi_ss_n, spi_sck, spi_mosi,
      output spi_miso,
      output vsd_ss_n,
      input  vsd_miso,
      output phys_ss_n, phys_sck, phys_mosi,
      input  phys_miso,
      output vsd_sel, reset_img, act_virt, act_phys
   );

   // Environment side: hps_io, core, card models and LEDs.
   modport slave (
      output img_mounted, img_present,
      output spi_ss_n, spi_sck, spi_mosi,
      input  spi_miso,
      input  vsd_ss_n,
      output vsd_miso,
      input  phys_ss_n, phys_sck, phys_mosi,
      output phys_miso,
      input  vsd_sel, reset_img, act_virt, act_phys
   );

endinterface

// File: rtl/sd_mount_ctrl_act_timer.sv
// Retriggerable saturating timer. A kick restarts the count at zero and the
// registered busy flag stays high for exactly CYCLES cycles after the last
// kick. Counting up to a saturation value is equivalent to loading CYCLES-1
// and counting down; the up-count form lets one module serve both the
// reset pulse and the activity LEDs.
module act_timer
   import sd_mount_pkg::*;
#(
   parameter int CYCLES = 8
) (
   input  logic clk_sys,
   input  logic reset,
   input  logic kick,
   output logic busy
);

   localparam int            W   = cnt_w(CYCLES);
   localparam logic [W-1:0]  SAT = W'(CYCLES);

   logic [W-1:0] cnt;

   // Count since the last kick, parked at SAT when idle; busy registered.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         cnt  <= SAT;
         busy <= 1'b0;
      end else if (kick) begin
         cnt  <= '0;
         busy <= 1'b1;
      end else if (cnt != SAT) begin
         cnt  <= cnt + 1'b1;
         busy <= (cnt + 1'b1) != SAT;
      end
   end

endmodule

// File: rtl/sd_mount_ctrl.sv
// N-slot SD routing and mount controller. Each image slot's chip-select is
// routed to a virtual sd_card or, for slot 0 only, to the physical SD pins.
// Any mount event raises a retriggerable core reset; SPI line activity is
// reported separately for virtual and physical cards.
module sd_mount_ctrl
   import sd_mount_pkg::*;
#(
   parameter int NUM_IMG      = 2,
   parameter int RESET_CYCLES = 10_000_000,
   parameter int ACT_CYCLES   = 1_000_000
) (
   input  logic         clk_sys,
   input  logic         reset,
   sd_mount_ctrl_if.master bus
);

   logic [NUM_IMG-1:0] vsd_sel_q;
   logic               phys_ss_n_w;
   logic               miso_mux;
   act_src_t           src;
   logic               mosi_q;
   logic               miso_q;
   logic               spi_edge;
   logic               kick_rst;
   logic               kick_virt;
   logic               kick_phys;
   logic               reset_img_w;
   logic               act_virt_w;
   logic               act_phys_w;

   // Latch the image-present state of every slot that strobes a mount.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         vsd_sel_q <= '0;
      end else begin
         for (int i = 0; i < NUM_IMG; i++) begin
            if (bus.img_mounted[i]) vsd_sel_q[i] <= bus.img_present[i];
         end
      end
   end

   // Chip-select routing: a slot reaches its virtual card only when an image
   // is mounted; slot 0 falls through to the physical card otherwise.
   assign bus.vsd_ss_n  = bus.spi_ss_n | ~vsd_sel_q;
   assign phys_ss_n_w   = bus.spi_ss_n[0] | vsd_sel_q[0];
   assign bus.phys_ss_n = phys_ss_n_w;
   assign bus.phys_sck  = bus.spi_sck  & ~phys_ss_n_w;
   assign bus.phys_mosi = bus.spi_mosi & ~phys_ss_n_w;

   // Pick the lowest-index selected slot and return its card's data.
   // Walking from the top down lets the lowest index overwrite the others.
   // NOTE: every output of a combinational block gets a default first so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      src      = SRC_NONE;
      miso_mux = 1'b1;
      for (int i = NUM_IMG - 1; i >= 0; i--) begin
         if (!bus.spi_ss_n[i]) begin
            if (vsd_sel_q[i]) begin
               src      = SRC_VIRT;
               miso_mux = bus.vsd_miso[i];
            end else if (i == 0) begin
               src      = SRC_PHYS;
               miso_mux = bus.phys_miso;
            end else begin
               src      = SRC_NONE;
               miso_mux = 1'b1;
            end
         end
      end
   end

   assign bus.spi_miso = miso_mux;

   // Previous-cycle copy of the data lines for edge detection.
   // NOTE: these are plain data delay flops with no reset; they settle on the
   // first clock and the timers they feed are held in reset meanwhile.
   always_ff @(posedge clk_sys) begin
      mosi_q <= bus.spi_mosi;
      miso_q <= miso_mux;
   end

   assign spi_edge  = (bus.spi_mosi != mosi_q) || (miso_mux != miso_q);
   assign kick_virt = spi_edge && (src == SRC_VIRT);
   assign kick_phys = spi_edge && (src == SRC_PHYS);
   assign kick_rst  = |bus.img_mounted;

   // Core reset request: held RESET_CYCLES cycles after the last mount.
   act_timer #(.CYCLES(RESET_CYCLES)) u_reset_timer (
      .clk_sys (clk_sys),
      .reset   (reset),
      .kick    (kick_rst),
      .busy    (reset_img_w)
   );

   // Virtual card activity LED.
   act_timer #(.CYCLES(ACT_CYCLES)) u_virt_timer (
      .clk_sys (clk_sys),
      .reset   (reset),
      .kick    (kick_virt),
      .busy    (act_virt_w)
   );

   // Physical card activity LED.
   act_timer #(.CYCLES(ACT_CYCLES)) u_phys_timer (
      .clk_sys (clk_sys),
      .reset   (reset),
      .kick    (kick_phys),
      .busy    (act_phys_w)
   );

   assign bus.vsd_sel   = vsd_sel_q;
   assign bus.reset_img = reset_img_w;
   assign bus.act_virt  = act_virt_w;
   assign bus.act_phys  = act_phys_w;

endmodule
